random_delay_timer: RTL and testbench

Parametrised pre-stimulus delay generator for the reaction speed tester. On a start request it waits either a fixed or a pseudo-random number of coarse ticks (default 0.1 s each), then raises `start_flag` to launch the measurement. While waiting it watches the player's button and flags a false start if the button is pressed early. It sits between the debounced button/control logic and the reaction-time counter, and replaces the fixed one-second delay.

---
 rtl/random_delay_timer.sv | 129 ++++++++++++
 tb/tb_random_delay_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/random_delay_timer.sv
// Pre-stimulus delay generator: waits a fixed or pseudo-random number of ticks,
// then raises start_flag; a button press while waiting is reported as a false start.
module random_delay_timer #(
  parameter int          CLK_HZ    = 100000000,
  parameter int          TICK_DIV  = CLK_HZ / 10,
  parameter int          CNT_W     = 8,
  parameter int          MIN_TICKS = 10,
  parameter int          MAX_TICKS = 100,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] fixed_ticks,
  input  logic             early_in,
  output logic             busy,
  output logic             start_flag,
  output logic             fire_pulse,
  output logic             false_start,
  output logic [CNT_W-1:0] delay_ticks
);

  // Handshake: start is a level, acted on only outside ARMED; abort wins over
  // start on the same edge; early_in is checked before expiry while ARMED.

  localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] RANGE_C = CNT_W'(MAX_TICKS - MIN_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2,
    S_FALSE = 2'd3
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [PRE_W-1:0] prescaler;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] rand_ticks;
  logic [CNT_W-1:0] req_ticks;

  // Galois form of x^16+x^14+x^13+x^11+1, free-running so draws depend on start timing.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    rand_ticks = MIN_C + (lfsr[CNT_W-1:0] % RANGE_C);
    req_ticks  = fixed_ticks;
    if (mode) begin
      req_ticks = rand_ticks;
    end else if (fixed_ticks == '0) begin
      req_ticks = CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      start_flag  <= 1'b0;
      fire_pulse  <= 1'b0;
      false_start <= 1'b0;
      delay_ticks <= '0;
      prescaler   <= '0;
      elapsed     <= '0;
    end else begin
      fire_pulse <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        start_flag  <= 1'b0;
        false_start <= 1'b0;
        prescaler   <= '0;
        elapsed     <= '0;
      end else begin
        case (state)
          S_IDLE, S_FIRED, S_FALSE: begin
            if (start) begin
              state       <= S_ARMED;
              busy        <= 1'b1;
              start_flag  <= 1'b0;
              false_start <= 1'b0;
              delay_ticks <= req_ticks;
              prescaler   <= '0;
              elapsed     <= '0;
            end
          end
          S_ARMED: begin
            if (early_in) begin
              state       <= S_FALSE;
              busy        <= 1'b0;
              false_start <= 1'b1;
              prescaler   <= '0;
              elapsed     <= '0;
            end else if (prescaler == PRE_TOP) begin
              prescaler <= '0;
              if (elapsed == delay_ticks - CNT_W'(1)) begin
                state      <= S_FIRED;
                busy       <= 1'b0;
                start_flag <= 1'b1;
                fire_pulse <= 1'b1;
                elapsed    <= '0;
              end else begin
                elapsed <= elapsed + CNT_W'(1);
              end
            end else begin
              prescaler <= prescaler + PRE_W'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer with short ticks (TICK_DIV=10, delays 2..5).
module tb_random_delay_timer;

  localparam int          TD   = 10;
  localparam int          MINT = 2;
  localparam int          MAXT = 5;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          RUN  = 60;

  logic       sysclk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       mode;
  logic [7:0] fixed_ticks;
  logic       early_in;
  logic       busy;
  logic       start_flag;
  logic       fire_pulse;
  logic       false_start;
  logic [7:0] delay_ticks;

  int n_checks;
  int n_fail;

  logic [15:0] m_lfsr;
  int          hist[MAXT+1];

  typedef struct {
    logic       md;
    logic [7:0] ft;
    int         early_at;
    int         abort_at;
    int         exp_delay;
    int         exp_fire;
    int         exp_false;
  } vec_t;

  vec_t vecs[8];

  random_delay_timer #(
    .CLK_HZ   (100),
    .TICK_DIV (TD),
    .CNT_W    (8),
    .MIN_TICKS(MINT),
    .MAX_TICKS(MAXT),
    .SEED     (SEED)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .fixed_ticks(fixed_ticks),
    .early_in   (early_in),
    .busy       (busy),
    .start_flag (start_flag),
    .fire_pulse (fire_pulse),
    .false_start(false_start),
    .delay_ticks(delay_ticks)
  );

  // clock / reference LFSR
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name, input int exp_delay);
    check({name, " busy"},        int'(busy),        0);
    check({name, " start_flag"},  int'(start_flag),  0);
    check({name, " fire_pulse"},  int'(fire_pulse),  0);
    check({name, " false_start"}, int'(false_start), 0);
    check({name, " delay_ticks"}, int'(delay_ticks), exp_delay);
  endtask

  // One start pulse followed by RUN observed cycles; times are edges after E0.
  task automatic run_case(input string name, input logic md, input logic [7:0] ft,
                          input int early_at, input int abort_at, input int exp_delay,
                          input int exp_fire, input int exp_false);
    int fire_t, pulse_t, pulses, false_t;
    fire_t = -1; pulse_t = -1; pulses = 0; false_t = -1;
    mode = md; fixed_ticks = ft; start = 1'b1; early_in = 1'b0; abort = 1'b0;
    step();
    start = 1'b0; mode = ~md; fixed_ticks = 8'hff;
    for (int k = 1; k <= RUN; k++) begin
      early_in = (k - 1 == early_at);
      abort    = (k - 1 == abort_at);
      step();
      if (k == 1) begin
        check({name, " busy@1"},        int'(busy),        1);
        check({name, " start_flag@1"},  int'(start_flag),  0);
        check({name, " false_start@1"}, int'(false_start), 0);
      end
      if (start_flag && fire_t < 0) fire_t = k;
      if (fire_pulse) begin
        pulses++;
        if (pulse_t < 0) pulse_t = k;
      end
      if (false_start && false_t < 0) false_t = k;
    end
    early_in = 1'b0; abort = 1'b0;
    check({name, " delay_ticks"}, int'(delay_ticks), exp_delay);
    check({name, " fire_time"},   fire_t,            exp_fire);
    check({name, " pulse_time"},  pulse_t,           exp_fire);
    check({name, " pulse_count"}, pulses,            (exp_fire >= 0) ? 1 : 0);
    check({name, " false_time"},  false_t,           exp_false);
    check({name, " busy_end"},    int'(busy),        0);
  endtask

  initial begin
    int fire_t, hold_cnt, e;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    fixed_ticks = '0; early_in = 1'b0;
    for (int v = 0; v <= MAXT; v++) hist[v] = 0;

    // mode, fixed, early_at, abort_at, exp_delay, exp_fire, exp_false
    vecs[0] = '{1'b0, 8'd3,  -1, -1, 3, 30, -1};
    vecs[1] = '{1'b0, 8'd0,  -1, -1, 1, 10, -1};
    vecs[2] = '{1'b0, 8'd3,  15, -1, 3, -1, 16};
    vecs[3] = '{1'b0, 8'd3,  29, -1, 3, -1, 30};
    vecs[4] = '{1'b0, 8'd3,  -1, 12, 3, -1, -1};
    vecs[5] = '{1'b0, 8'd5,  -1, -1, 5, 50, -1};
    vecs[6] = '{1'b0, 8'd1,   9, -1, 1, -1, 10};
    vecs[7] = '{1'b0, 8'd2,  20, -1, 2, 20, -1};

    repeat (3) step();
    check_idle_outputs("reset", 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_case($sformatf("vec%0d", i), vecs[i].md, vecs[i].ft, vecs[i].early_at,
               vecs[i].abort_at, vecs[i].exp_delay, vecs[i].exp_fire, vecs[i].exp_false);
    end

    // start and abort together from FIRED: abort wins, delay_ticks kept
    mode = 1'b0; fixed_ticks = 8'd4; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_idle_outputs("start_abort", 2);
    step();
    check("start_abort busy_later", int'(busy), 0);

    // start held high through ARMED: no restart, then re-arm from FIRED
    fixed_ticks = 8'd3; start = 1'b1;
    step();
    fire_t = -1;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (start_flag && fire_t < 0) fire_t = k;
    end
    check("held_start fire_time", fire_t, 30);
    check("held_start rearm_busy", int'(busy), 1);
    check("held_start rearm_flag", int'(start_flag), 0);
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check("held_start abort_busy", int'(busy), 0);

    // synchronous reset while ARMED
    fixed_ticks = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("mid_reset", 0);
    hold_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (start_flag || fire_pulse || busy) hold_cnt++;
    end
    check("mid_reset no_activity", hold_cnt, 0);

    // random draws against the reference LFSR
    for (int r = 0; r < 200; r++) begin
      e = MINT + int'(m_lfsr[7:0] % 8'd4);
      hist[e]++;
      run_case($sformatf("rand%0d", r), 1'b1, 8'd0, -1, -1, e, e * TD, -1);
    end
    for (int v = MINT; v <= MAXT; v++) begin
      check($sformatf("rand_hist%0d_seen", v), int'(hist[v] > 0), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
